register_in_collect: RTL and testbench

- Downstream consumer of the likelihood-array bit-serial output stage.
- Takes one serial bit per lane per valid cycle, MSB first, and rebuilds 2**Nword-bit words for all 2**Narray lanes.
- Presents each completed frame on a valid/ready output register to the Bayesian inference/accumulation logic.
- Decouples the serial stream from a possibly stalling consumer and flags dropped frames.

---
 rtl/bayes_pkg.sv | 10 +
 rtl/lane_popcount.sv | 15 +
 rtl/register_in_collect.sv | 78 +++++++
 tb/tb_register_in_collect.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/bayes_pkg.sv
// bayes_pkg: shared sizes, lane word/count types and collector FSM states.
package bayes_pkg;
  localparam int Narray = 2;
  localparam int Nword = 3;
  localparam int NLANE = 1 << Narray;
  localparam int WORD_W = 1 << Nword;
  typedef logic [WORD_W-1:0] word_t;
  typedef logic [Nword:0] cnt_t;
  typedef enum logic {IDLE, COLLECT} state_t;
endpackage

// File: rtl/lane_popcount.sv
// lane_popcount: number of 1 bits in one lane word.
// Exists only when REGISTER_IN_POPCOUNT_EN is defined.
`ifdef REGISTER_IN_POPCOUNT_EN
module lane_popcount
  import bayes_pkg::*;
(
  input  word_t word,
  output cnt_t  ones
);
  always_comb begin
    ones = '0;
    for (int k = 0; k < WORD_W; k++) ones = ones + cnt_t'(word[k]);
  end
endmodule
`endif

// File: rtl/register_in_collect.sv
// register_in_collect: rebuilds MSB-first serial lane bits into words behind a valid/ready output register.
// REGISTER_IN_POPCOUNT_EN adds a registered per-lane popcount on ones_count.
module register_in_collect
  import bayes_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_valid,
  input  logic [NLANE-1:0] data_in,
  input  logic             frame_abort,
  output word_t            word_out [NLANE],
  output cnt_t             ones_count [NLANE],
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overflow,
  output logic             busy
);
  state_t state_q, state_d;
  cnt_t   cnt_q, cnt_d;
  word_t  sh_q [NLANE];
  word_t  sh_d [NLANE];
  word_t  nw [NLANE];
  word_t  word_q [NLANE];
  word_t  word_d [NLANE];
  logic   out_valid_q, out_valid_d, overflow_q, overflow_d, done, load;
  always_comb begin
    done = bit_valid && !frame_abort && cnt_q == cnt_t'(WORD_W - 1);
    load = done && (!out_valid_q || out_ready);
    state_d = frame_abort ? IDLE : bit_valid ? (done ? IDLE : COLLECT) : state_q;
    cnt_d = (frame_abort || done) ? '0 : bit_valid ? cnt_q + 1'b1 : cnt_q;
    out_valid_d = load ? 1'b1 : (out_valid_q && out_ready) ? 1'b0 : out_valid_q;
    overflow_d = overflow_q || (done && !load);
    for (int i = 0; i < NLANE; i++) begin
      nw[i] = {sh_q[i][WORD_W-2:0], data_in[i]};
      sh_d[i] = (frame_abort || done) ? '0 : bit_valid ? nw[i] : sh_q[i];
      word_d[i] = load ? nw[i] : word_q[i];
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      sh_q <= '{default: '0};
      word_q <= '{default: '0};
      out_valid_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      sh_q <= sh_d;
      word_q <= word_d;
      out_valid_q <= out_valid_d;
      overflow_q <= overflow_d;
    end
  end
`ifdef REGISTER_IN_POPCOUNT_EN
  cnt_t pc [NLANE];
  cnt_t ones_q [NLANE];
  cnt_t ones_d [NLANE];
  for (genvar g = 0; g < NLANE; g++) begin : g_pc
    lane_popcount u_pc (.word(nw[g]), .ones(pc[g]));
  end
  always_comb begin
    for (int i = 0; i < NLANE; i++) ones_d[i] = load ? pc[i] : ones_q[i];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ones_q <= '{default: '0};
    else ones_q <= ones_d;
  end
  assign ones_count = ones_q;
`else
  assign ones_count = '{default: '0};
`endif
  assign word_out = word_q;
  assign out_valid = out_valid_q;
  assign overflow = overflow_q;
  assign busy = state_q == COLLECT;
endmodule

// File: tb/tb_register_in_collect.sv
// tb_register_in_collect: directed checks of frame rebuild, gaps, overflow, simultaneous accept, abort and async reset.
module tb_register_in_collect;
  import bayes_pkg::*;
  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             bit_valid = 1'b0;
  logic [NLANE-1:0] data_in = '0;
  logic             frame_abort = 1'b0;
  logic             out_ready = 1'b1;
  word_t            word_out [NLANE];
  cnt_t             ones_count [NLANE];
  logic             out_valid, overflow, busy;
  logic [7:0]       fw [NLANE];
  logic [7:0]       ew [NLANE];
  int               n_vec = 0;
  int               n_err = 0;

  register_in_collect dut (
    .clk(clk), .rst_n(rst_n), .bit_valid(bit_valid), .data_in(data_in),
    .frame_abort(frame_abort), .word_out(word_out), .ones_count(ones_count),
    .out_valid(out_valid), .out_ready(out_ready), .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_ones(input logic [7:0] w);
`ifdef REGISTER_IN_POPCOUNT_EN
    return 32'($countones(w));
`else
    return 32'd0;
`endif
  endfunction

  task automatic chk_words(input string tag);
    for (int i = 0; i < NLANE; i++) begin
      chk($sformatf("%s word[%0d]", tag, i), 32'(word_out[i]), 32'(ew[i]));
      chk($sformatf("%s ones[%0d]", tag, i), 32'(ones_count[i]), exp_ones(ew[i]));
    end
  endtask

  task automatic set_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
    fw[0] = a; fw[1] = b; fw[2] = c; fw[3] = d;
  endtask

  task automatic hold_exp;
    for (int i = 0; i < NLANE; i++) ew[i] = fw[i];
  endtask

  task automatic feed(input int lo, input int hi);
    for (int b = lo; b <= hi; b++) begin
      bit_valid = 1'b1;
      for (int i = 0; i < NLANE; i++) data_in[i] = fw[i][7-b];
      @(posedge clk); #1;
      bit_valid = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    #1;
    ew = '{default: 8'h00};
    chk("reset out_valid", 32'(out_valid), 0);
    chk("reset busy", 32'(busy), 0);
    chk("reset overflow", 32'(overflow), 0);
    chk_words("reset");
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    // Basic frame, consumer always ready
    set_frame(8'hA5, 8'h3C, 8'hFF, 8'h00);
    feed(0, 0);
    chk("basic busy after bit0", 32'(busy), 1);
    feed(1, 7);
    hold_exp();
    chk("basic out_valid", 32'(out_valid), 1);
    chk("basic busy done", 32'(busy), 0);
    chk_words("basic");
    idle(1);
    chk("basic accepted", 32'(out_valid), 0);
    // Same frame with a 3-cycle gap after bit 4
    feed(0, 3);
    for (int g = 0; g < 3; g++) begin
      idle(1);
      chk("gap busy", 32'(busy), 1);
    end
    chk("gap no output", 32'(out_valid), 0);
    feed(4, 7);
    chk("gap out_valid", 32'(out_valid), 1);
    chk_words("gap");
    idle(1);
    // Overflow: frame 1 held, frame 2 dropped
    out_ready = 1'b0;
    set_frame(8'h11, 8'h22, 8'h33, 8'h44);
    feed(0, 7);
    hold_exp();
    chk("ovf f1 valid", 32'(out_valid), 1);
    chk("ovf f1 overflow", 32'(overflow), 0);
    set_frame(8'h55, 8'h66, 8'h77, 8'h88);
    feed(0, 7);
    chk("ovf overflow set", 32'(overflow), 1);
    chk("ovf still valid", 32'(out_valid), 1);
    chk_words("ovf held f1");
    out_ready = 1'b1;
    idle(1);
    out_ready = 1'b0;
    chk("ovf accept clears", 32'(out_valid), 0);
    idle(2);
    chk("ovf sticky", 32'(overflow), 1);
    rst_n = 1'b0; #2;
    chk("ovf reset clears", 32'(overflow), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    // Simultaneous accept on the completion edge
    set_frame(8'h01, 8'h02, 8'h03, 8'h04);
    feed(0, 7);
    chk("sim f1 valid", 32'(out_valid), 1);
    set_frame(8'h0A, 8'h0B, 8'h0C, 8'h0D);
    feed(0, 6);
    out_ready = 1'b1;
    feed(7, 7);
    hold_exp();
    chk("sim valid stays", 32'(out_valid), 1);
    chk("sim no overflow", 32'(overflow), 0);
    chk_words("sim f2");
    idle(1);
    chk("sim accepted", 32'(out_valid), 0);
    // Abort after bit 5 with a coincident valid bit
    set_frame(8'hFF, 8'hFF, 8'hFF, 8'hFF);
    feed(0, 4);
    frame_abort = 1'b1;
    feed(5, 5);
    frame_abort = 1'b0;
    chk("abort busy", 32'(busy), 0);
    chk("abort no output", 32'(out_valid), 0);
    set_frame(8'h81, 8'h81, 8'h81, 8'h81);
    feed(0, 6);
    chk("abort fresh no early output", 32'(out_valid), 0);
    feed(7, 7);
    hold_exp();
    chk("abort fresh valid", 32'(out_valid), 1);
    chk_words("abort fresh");
    idle(1);
    // Async reset mid-frame with a frame held at the output
    out_ready = 1'b0;
    set_frame(8'hC3, 8'h96, 8'h0F, 8'hF0);
    feed(0, 7);
    hold_exp();
    chk_words("pre-reset held");
    set_frame(8'hE7, 8'hE7, 8'hE7, 8'hE7);
    feed(0, 2);
    chk("pre-reset busy", 32'(busy), 1);
    #3 rst_n = 1'b0;
    #1;
    ew = '{default: 8'h00};
    chk("areset out_valid", 32'(out_valid), 0);
    chk("areset busy", 32'(busy), 0);
    chk_words("areset");
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    set_frame(8'h5A, 8'hC0, 8'h07, 8'h99);
    feed(0, 7);
    hold_exp();
    chk("post-reset valid", 32'(out_valid), 1);
    chk("post-reset overflow", 32'(overflow), 0);
    chk_words("post-reset");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
